// File: rtl/systolic_pkg.sv
// Shared types and defaults for the systolic operand feeder.
// Optional build macro: FEEDER_TIMEOUT_EN (WAIT_DONE watchdog).
package systolic_pkg;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned DEF_SIZE  = 16;
  localparam int unsigned DEF_DEPTH = 16;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_ARMED     = 3'd2,
    ST_STREAM    = 3'd3,
    ST_WAIT_DONE = 3'd4
  } feeder_state_e;

endpackage

// File: rtl/systolic_operand_feeder_if.sv
// Load handshake, launch control and array-side bus for the operand feeder.
// Optional build macro: FEEDER_TIMEOUT_EN (drives err_timeout).
interface systolic_operand_feeder_if
  import systolic_pkg::*;
#(
  parameter int unsigned SIZE  = DEF_SIZE,
  parameter int unsigned DEPTH = DEF_DEPTH
);

  logic                                   ld_valid;
  logic                                   ld_ready;
  logic signed [SIZE-1:0][DATA_W-1:0]     ld_weight;
  logic signed [SIZE-1:0][DATA_W-1:0]     ld_input;
  logic                                   ld_last;
  logic                                   go;
  logic                                   accumulate_req;
  logic                                   arr_start;
  logic                                   arr_accumulate;
  logic signed [SIZE-1:0][DATA_W-1:0]     arr_weight;
  logic signed [SIZE-1:0][DATA_W-1:0]     arr_input;
  logic                                   arr_done;
  logic                                   busy;
  logic [$clog2(DEPTH+1)-1:0]             k_count;
  logic                                   err_timeout;

  // Host / array side that drives the feeder
  modport master (
    output ld_valid, ld_weight, ld_input, ld_last, go, accumulate_req, arr_done,
    input  ld_ready, arr_start, arr_accumulate, arr_weight, arr_input,
           busy, k_count, err_timeout
  );

  // Feeder side
  modport slave (
    input  ld_valid, ld_weight, ld_input, ld_last, go, accumulate_req, arr_done,
    output ld_ready, arr_start, arr_accumulate, arr_weight, arr_input,
           busy, k_count, err_timeout
  );

endinterface

// File: rtl/operand_skew_buffer.sv
// Tile storage for weight/input vectors plus diagonal skew read-out:
// lane i at stream cycle t shows vector[t-i] element i, else 0.
// Optional build macro: FEEDER_TIMEOUT_EN (not used here).
module operand_skew_buffer
  import systolic_pkg::*;
#(
  parameter int unsigned SIZE  = DEF_SIZE,
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned KW    = $clog2(DEPTH + 1),
  parameter int unsigned TW    = $clog2(DEPTH + SIZE)
) (
  input  logic                               clock,
  input  logic                               we_i,
  input  logic [KW-1:0]                      waddr_i,
  input  logic signed [SIZE-1:0][DATA_W-1:0] wdata_w_i,
  input  logic signed [SIZE-1:0][DATA_W-1:0] wdata_x_i,
  input  logic                               rd_en_i,
  input  logic [TW-1:0]                      t_i,
  input  logic [KW-1:0]                      k_i,
  output logic signed [SIZE-1:0][DATA_W-1:0] lane_w_o,
  output logic signed [SIZE-1:0][DATA_W-1:0] lane_x_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [SIZE-1:0][DATA_W-1:0] mem_w_q [DEPTH];
  logic [SIZE-1:0][DATA_W-1:0] mem_x_q [DEPTH];

  // Capture accepted vectors; contents are qualified by k_i, so no reset needed
  always_ff @(posedge clock) begin
    if (we_i) begin
      mem_w_q[AW'(waddr_i)] <= wdata_w_i;
      mem_x_q[AW'(waddr_i)] <= wdata_x_i;
    end
  end

  // Skewed lane selection; all lanes read 0 when not streaming
  always_comb begin
    int d;
    d        = 0;
    lane_w_o = '0;
    lane_x_o = '0;
    if (rd_en_i) begin
      for (int unsigned i = 0; i < SIZE; i++) begin
        d = int'(t_i) - int'(i);
        if (d >= 0 && d < int'(k_i)) begin
          lane_w_o[i] = mem_w_q[AW'(d)][i];
          lane_x_o[i] = mem_x_q[AW'(d)][i];
        end
      end
    end
  end

endmodule

// File: rtl/systolic_operand_feeder.sv
// Loads a tile of K operand vectors, then streams them diagonally skewed
// into a SIZE x SIZE systolic array and waits for its completion pulse.
// Optional build macro: FEEDER_TIMEOUT_EN enables a WAIT_DONE watchdog that
// sets sticky err_timeout after TIMEOUT cycles and returns to IDLE.
module systolic_operand_feeder
  import systolic_pkg::*;
#(
  parameter int unsigned SIZE    = DEF_SIZE,
  parameter int unsigned DEPTH   = DEF_DEPTH,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                    clock,
  input  logic                    reset,
  systolic_operand_feeder_if.slave bus
);

  localparam int unsigned KW = $clog2(DEPTH + 1);
  localparam int unsigned TW = $clog2(DEPTH + SIZE);

  feeder_state_e state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [TW-1:0] t_q, t_d;
  logic          acc_q, acc_d;

  logic          ld_ready;
  logic          xfer;
  logic          streaming;
  logic [TW-1:0] last_t;

  logic signed [SIZE-1:0][DATA_W-1:0] lane_w;
  logic signed [SIZE-1:0][DATA_W-1:0] lane_x;

`ifdef FEEDER_TIMEOUT_EN
  localparam int unsigned WW = $clog2(TIMEOUT + 1);
  logic [WW-1:0] wd_q, wd_d;
  logic          err_q, err_d;
`endif

  assign ld_ready  = (state_q == ST_IDLE) || (state_q == ST_LOAD);
  assign xfer      = bus.ld_valid && ld_ready;
  assign streaming = (state_q == ST_STREAM);
  assign last_t    = TW'(k_q) + TW'(SIZE - 2);

  // Next-state logic for the tile lifecycle
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    t_d     = t_q;
    acc_d   = acc_q;
`ifdef FEEDER_TIMEOUT_EN
    wd_d    = wd_q;
    err_d   = err_q;
`endif
    case (state_q)
      // A single-vector tile marked last goes straight to ARMED so no
      // further transfer can be accepted into a closed tile.
      ST_IDLE, ST_LOAD: begin
        if (xfer) begin
          k_d = k_q + KW'(1);
          if (bus.ld_last || (k_q == KW'(DEPTH - 1))) state_d = ST_ARMED;
          else                                         state_d = ST_LOAD;
        end
      end
      ST_ARMED: begin
        if (bus.go) begin
          acc_d   = bus.accumulate_req;
          t_d     = '0;
          state_d = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (t_q == last_t) begin
          t_d     = '0;
          state_d = ST_WAIT_DONE;
`ifdef FEEDER_TIMEOUT_EN
          wd_d    = '0;
`endif
        end else begin
          t_d = t_q + TW'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (bus.arr_done) begin
          k_d     = '0;
          state_d = ST_IDLE;
        end
`ifdef FEEDER_TIMEOUT_EN
        else if (wd_q == WW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          k_d     = '0;
          state_d = ST_IDLE;
        end else begin
          wd_d = wd_q + WW'(1);
        end
`endif
      end
      default: begin
        state_d = ST_IDLE;
        k_d     = '0;
      end
    endcase
  end

  // Control state registers; reset discards any tile in progress
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      t_q     <= '0;
      acc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      t_q     <= t_d;
      acc_q   <= acc_d;
    end
  end

`ifdef FEEDER_TIMEOUT_EN
  // Watchdog counter and sticky timeout flag
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end
  assign bus.err_timeout = err_q;
`else
  assign bus.err_timeout = 1'b0;
`endif

  operand_skew_buffer #(
    .SIZE  (SIZE),
    .DEPTH (DEPTH),
    .KW    (KW),
    .TW    (TW)
  ) u_skew (
    .clock     (clock),
    .we_i      (xfer),
    .waddr_i   (k_q),
    .wdata_w_i (bus.ld_weight),
    .wdata_x_i (bus.ld_input),
    .rd_en_i   (streaming),
    .t_i       (t_q),
    .k_i       (k_q),
    .lane_w_o  (lane_w),
    .lane_x_o  (lane_x)
  );

  assign bus.ld_ready       = ld_ready;
  assign bus.arr_start      = streaming && (t_q == '0);
  assign bus.arr_accumulate = streaming && acc_q;
  assign bus.arr_weight     = lane_w;
  assign bus.arr_input      = lane_x;
  assign bus.busy           = (state_q != ST_IDLE);
  assign bus.k_count        = k_q;

endmodule
